// File: rtl/spram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
//   arb_state_e : arbiter FSM states (HOLD is only reachable with SPRAM_ARB_BURST_EN)
//   rd_tag_t    : one read-pipeline stage {valid, requester id}
//   req_id_w    : width of a requester index for a given requester count
//   rr_pick     : round-robin pick, returns a one-hot grant over up to MAX_REQ requesters
package spram_arb_pkg;

  localparam int MAX_REQ  = 8;
  localparam int MAX_ID_W = 3;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } rd_tag_t;

  // A single requester still needs a one-bit index to keep port widths legal.
  function automatic int req_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Search starts at ptr and wraps at n; the first valid requester wins.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0]  valid,
    input logic [MAX_ID_W-1:0] ptr,
    input int                  n
  );
    logic [MAX_REQ-1:0]  grant;
    logic                found;
    logic [MAX_ID_W-1:0] idx;
    grant = {MAX_REQ{1'b0}};
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = MAX_ID_W'((32'(ptr) + 32'(i)) % 32'(n));
      if ((i < n) && !found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/spram_arbiter_if.sv
// Requester and RAM-side bus of spram_arbiter.
//   i_req_valid/we/addr/wdata : per-requester commands, requester 0 in the LSBs
//   o_req_ready               : one-hot grant, command accepted on valid & ready
//   o_rsp_valid/o_rsp_data    : read response, data bus shared by all requesters
//   o_ram_we/addr/wdata       : registered command to the RAM instance
//   i_ram_rdata               : read data returned by the RAM
// slave  : the arbiter side; master : requesters plus the RAM model.
interface spram_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ-1:0]            i_req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic [NUM_REQ-1:0]            o_rsp_valid;
  logic [DATA_WIDTH-1:0]         o_rsp_data;
  logic                          o_ram_we;
  logic [ADDR_WIDTH-1:0]         o_ram_addr;
  logic [DATA_WIDTH-1:0]         o_ram_wdata;
  logic [DATA_WIDTH-1:0]         i_ram_rdata;

  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_ram_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_ram_we, o_ram_addr, o_ram_wdata
  );

  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_ram_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_ram_we, o_ram_addr, o_ram_wdata
  );
endinterface

// File: rtl/spram_arbiter_rr_arbiter.sv
// Round-robin picker with a registered priority pointer.
//   clk, rst_n : clock, synchronous active-low reset
//   valid      : per-requester request
//   accept     : a command was accepted this cycle
//   accept_id  : index of the accepted requester
//   grant      : one-hot pick among valid requesters, starting at the pointer
// After an accept by k the pointer moves to k+1 (mod NUM_REQ); otherwise it holds.
module rr_arbiter
  import spram_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int REQ_ID_W = req_id_w(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  valid,
  input  logic                accept,
  input  logic [REQ_ID_W-1:0] accept_id,
  output logic [NUM_REQ-1:0]  grant
);

  logic [REQ_ID_W-1:0] ptr_r;

  // Combinational pick from the current pointer.
  always_comb begin
    grant = NUM_REQ'(rr_pick(MAX_REQ'(valid), MAX_ID_W'(ptr_r), NUM_REQ));
  end

  // Priority pointer: the requester after the last accepted one gets first look.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= {REQ_ID_W{1'b0}};
    end else if (accept) begin
      if (accept_id == REQ_ID_W'(NUM_REQ - 1)) begin
        ptr_r <= {REQ_ID_W{1'b0}};
      end else begin
        ptr_r <= accept_id + REQ_ID_W'(1);
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/spram_arbiter.sv
// Shares one single-port RAM between NUM_REQ requesters.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : spram_arbiter_if.slave (requester commands/grants/responses, RAM command/read data)
// Commands are granted round-robin, registered onto o_ram_* one cycle after accept,
// and reads are tagged through an RD_LATENCY+1 stage pipeline so that o_rsp_valid
// pulses for the issuing requester exactly when i_ram_rdata carries its data.
// Optional build macro SPRAM_ARB_BURST_EN: a granted requester keeps the grant for
// up to BURST_LEN consecutive accepts while it stays valid (FSM state HOLD).
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int BURST_LEN  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  spram_arbiter_if.slave  bus
);

  localparam int REQ_ID_W = req_id_w(NUM_REQ);

  logic [NUM_REQ-1:0]    pick_s;
  logic [NUM_REQ-1:0]    ready_s;
  logic                  accept_s;
  logic [REQ_ID_W-1:0]   accept_id_s;
  logic                  accept_we_s;
  logic [ADDR_WIDTH-1:0] accept_addr_s;
  logic [DATA_WIDTH-1:0] accept_wdata_s;
  rd_tag_t               tag_in_s;
  logic [NUM_REQ-1:0]    rsp_valid_s;

  arb_state_e            state_r;
  logic                  ram_we_r;
  logic [ADDR_WIDTH-1:0] ram_addr_r;
  logic [DATA_WIDTH-1:0] ram_wdata_r;
  rd_tag_t               rd_pipe_r [RD_LATENCY+1];

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .REQ_ID_W (REQ_ID_W)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (bus.i_req_valid),
    .accept    (accept_s),
    .accept_id (accept_id_s),
    .grant     (pick_s)
  );

`ifdef SPRAM_ARB_BURST_EN
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  logic [CNT_W-1:0]    burst_cnt_r;
  logic [REQ_ID_W-1:0] hold_id_r;
  logic                burst_active_s;
  logic [NUM_REQ-1:0]  hold_grant_s;

  // In HOLD the owner keeps the grant only while valid; otherwise fall back to
  // the round-robin pick in the same cycle so no bubble is inserted.
  always_comb begin
    burst_active_s          = (state_r == HOLD) && bus.i_req_valid[hold_id_r];
    hold_grant_s            = {NUM_REQ{1'b0}};
    hold_grant_s[hold_id_r] = 1'b1;
    if (burst_active_s) begin
      ready_s = hold_grant_s;
    end else begin
      ready_s = pick_s;
    end
  end

  // Arbiter FSM with burst counter. The counter is only reset on a fresh
  // (round-robin) accept, so it counts accepts of the current owner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ARB;
      burst_cnt_r <= {CNT_W{1'b0}};
      hold_id_r   <= {REQ_ID_W{1'b0}};
    end else begin
      case (state_r)
        ARB: begin
          if (accept_s) begin
            burst_cnt_r <= CNT_W'(1);
            hold_id_r   <= accept_id_s;
            state_r     <= (BURST_LEN > 1) ? HOLD : ARB;
          end else begin
            state_r <= ARB;
          end
        end
        HOLD: begin
          if (burst_active_s) begin
            burst_cnt_r <= burst_cnt_r + CNT_W'(1);
            state_r     <= ((burst_cnt_r + CNT_W'(1)) >= CNT_W'(BURST_LEN)) ? ARB : HOLD;
          end else if (accept_s) begin
            burst_cnt_r <= CNT_W'(1);
            hold_id_r   <= accept_id_s;
            state_r     <= (BURST_LEN > 1) ? HOLD : ARB;
          end else begin
            state_r <= ARB;
          end
        end
        default: begin
          state_r <= ARB;
        end
      endcase
    end
  end
`else
  // Grant is re-arbitrated every cycle.
  always_comb begin
    ready_s = pick_s;
  end

  // Without bursting the FSM never leaves ARB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ARB;
    end else begin
      state_r <= ARB;
    end
  end
`endif

  // Decode the accepted command; ready is one-hot so OR-ing indices is exact.
  always_comb begin
    accept_s    = |(ready_s & bus.i_req_valid);
    accept_id_s = {REQ_ID_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      accept_id_s = accept_id_s | (ready_s[i] ? REQ_ID_W'(i) : {REQ_ID_W{1'b0}});
    end
    accept_we_s    = bus.i_req_we[accept_id_s];
    accept_addr_s  = bus.i_req_addr[32'(accept_id_s) * ADDR_WIDTH +: ADDR_WIDTH];
    accept_wdata_s = bus.i_req_wdata[32'(accept_id_s) * DATA_WIDTH +: DATA_WIDTH];
    tag_in_s.valid = accept_s && !accept_we_s;
    tag_in_s.id    = MAX_ID_W'(accept_id_s);
  end

  // RAM command registers: idle cycles drop the write enable but hold the address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_we_r    <= 1'b0;
      ram_addr_r  <= {ADDR_WIDTH{1'b0}};
      ram_wdata_r <= {DATA_WIDTH{1'b0}};
    end else if (accept_s) begin
      ram_we_r    <= accept_we_s;
      ram_addr_r  <= accept_addr_s;
      ram_wdata_r <= accept_wdata_s;
    end else begin
      ram_we_r    <= 1'b0;
      ram_addr_r  <= ram_addr_r;
      ram_wdata_r <= ram_wdata_r;
    end
  end

  // Read tag pipeline: stage 0 lines up with the RAM command, the last stage with
  // the returned data. Reset flushes in-flight reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j <= RD_LATENCY; j++) begin
        rd_pipe_r[j] <= '0;
      end
    end else begin
      rd_pipe_r[0] <= tag_in_s;
      for (int j = 1; j <= RD_LATENCY; j++) begin
        rd_pipe_r[j] <= rd_pipe_r[j-1];
      end
    end
  end

  // Response valid is a pure decode of the last pipeline stage.
  always_comb begin
    rsp_valid_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_s[i] = rd_pipe_r[RD_LATENCY].valid && (rd_pipe_r[RD_LATENCY].id == MAX_ID_W'(i));
    end
  end

  assign bus.o_req_ready = ready_s;
  assign bus.o_rsp_valid = rsp_valid_s;
  assign bus.o_rsp_data  = bus.i_ram_rdata;
  assign bus.o_ram_we    = ram_we_r;
  assign bus.o_ram_addr  = ram_addr_r;
  assign bus.o_ram_wdata = ram_wdata_r;

endmodule

// File: tb/tb_spram_arbiter.sv
// Self-checking bench for spram_arbiter (NUM_REQ=2, RD_LATENCY=1).
// A vector table drives requester commands and states the expected grant; every
// accepted command pushes its expected RAM command and (for reads) its expected
// response into scoreboard queues, which a negedge monitor pops and compares.
module tb_spram_arbiter;

  localparam int NR  = 2;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int RDL = 1;

  typedef struct {
    string       name;
    logic [1:0]  valid;
    logic [1:0]  we;
    logic [7:0]  addr0;
    logic [7:0]  addr1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic [1:0]  exp_ready;
  } vec_t;

  typedef struct {
    int          due;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  cmd_t        cmd_q[$];
  rsp_t        rsp_q[$];
  vec_t        tbl[$];
  logic [31:0] model_mem [0:255];
  logic [31:0] ram [0:255];
  logic [31:0] ram_rdata_r;

  always #5 clk = ~clk;

  spram_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  spram_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RD_LATENCY (RDL),
    .BURST_LEN  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Single-port RAM, one cycle read latency, read-before-write.
  always @(posedge clk) begin
    if (bus.o_ram_we) ram[bus.o_ram_addr] <= bus.o_ram_wdata;
    ram_rdata_r <= ram[bus.o_ram_addr];
  end
  assign bus.i_ram_rdata = ram_rdata_r;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [1:0] va, input logic [1:0] w,
                              input logic [7:0] a0, input logic [7:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [1:0] er);
    vec_t v;
    v.name = n; v.valid = va; v.we = w; v.addr0 = a0; v.addr1 = a1;
    v.wd0 = d0; v.wd1 = d1; v.exp_ready = er;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic [7:0]  a;
    logic [31:0] d;
    @(posedge clk); #1;
    bus.i_req_valid = v.valid;
    bus.i_req_we    = v.we;
    bus.i_req_addr  = {v.addr1, v.addr0};
    bus.i_req_wdata = {v.wd1, v.wd0};
    @(negedge clk);
    chk({v.name, " ready"}, 64'(bus.o_req_ready), 64'(v.exp_ready));
    for (int k = 0; k < NR; k++) begin
      if (v.exp_ready[k] && v.valid[k]) begin
        a = (k == 0) ? v.addr0 : v.addr1;
        d = (k == 0) ? v.wd0 : v.wd1;
        if (v.we[k]) begin
          cmd_q.push_back('{cyc + 1, 1'b1, a, d});
          model_mem[a] = d;
        end else begin
          cmd_q.push_back('{cyc + 1, 1'b0, a, d});
          rsp_q.push_back('{cyc + 1 + RDL, k, model_mem[a]});
        end
      end
    end
  endtask

  // Scoreboard monitor: RAM command and response checked every cycle.
  always @(negedge clk) begin : mon
    cmd_t c;
    rsp_t r;
    if (mon_en) begin
      if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
        c = cmd_q.pop_front();
        chk("ram_we", 64'(bus.o_ram_we), 64'(c.we));
        chk("ram_addr", 64'(bus.o_ram_addr), 64'(c.addr));
        if (c.we) chk("ram_wdata", 64'(bus.o_ram_wdata), 64'(c.wdata));
      end else begin
        chk("ram_we idle", 64'(bus.o_ram_we), 64'(0));
      end
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        r = rsp_q.pop_front();
        chk("rsp_valid", 64'(bus.o_rsp_valid), 64'(1) << r.id);
        chk("rsp_data", 64'(bus.o_rsp_data), 64'(r.data));
      end else begin
        chk("rsp_valid idle", 64'(bus.o_rsp_valid), 64'(0));
      end
    end
  end

  initial begin
    logic [1:0] er;
    rst_n           = 1'b0;
    bus.i_req_valid = 2'b00;
    bus.i_req_we    = 2'b00;
    bus.i_req_addr  = 16'h0000;
    bus.i_req_wdata = 64'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ram_we", 64'(bus.o_ram_we), 64'(0));
    chk("reset ram_addr", 64'(bus.o_ram_addr), 64'(0));
    chk("reset ram_wdata", 64'(bus.o_ram_wdata), 64'(0));
    chk("reset rsp_valid", 64'(bus.o_rsp_valid), 64'(0));
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Idle after reset.
    for (int k = 0; k < 10; k++) tbl.push_back(mk("idle", 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 2'b00));

    // Both requesters write continuously; each presents the next item of the
    // 0x10.. / 0xA0.. sequence, so accept order determines the RAM stream.
    for (int k = 0; k < 8; k++) begin
`ifdef SPRAM_ARB_BURST_EN
      er = (k < 4) ? 2'b01 : 2'b10;
`else
      er = k[0] ? 2'b10 : 2'b01;
`endif
      tbl.push_back(mk("wr_both", 2'b11, 2'b11, 8'h10 + 8'(k), 8'h10 + 8'(k),
                       32'hA0 + 32'(k), 32'hA0 + 32'(k), er));
    end

    // Write then read-after-write of the same address by the other requester.
    tbl.push_back(mk("wr_dead", 2'b01, 2'b01, 8'h05, 8'h00, 32'hDEADBEEF, 32'h0, 2'b01));
    tbl.push_back(mk("raw_rd", 2'b10, 2'b00, 8'h00, 8'h05, 32'h0, 32'h0, 2'b10));
    for (int k = 0; k < 3; k++) tbl.push_back(mk("drain", 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 2'b00));

    // Back-to-back reads from alternating requesters.
    tbl.push_back(mk("b2b_rd0", 2'b01, 2'b00, 8'h10, 8'h00, 32'h0, 32'h0, 2'b01));
    tbl.push_back(mk("b2b_rd1", 2'b10, 2'b00, 8'h00, 8'h11, 32'h0, 32'h0, 2'b10));
    tbl.push_back(mk("b2b_rd2", 2'b01, 2'b00, 8'h12, 8'h00, 32'h0, 32'h0, 2'b01));
    for (int k = 0; k < 3; k++) tbl.push_back(mk("drain", 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 2'b00));

    foreach (tbl[i]) apply(tbl[i]);

    // Reset one cycle after a read accept: the response must never appear.
    apply(mk("rd_pre_rst", 2'b01, 2'b00, 8'h13, 8'h00, 32'h0, 32'h0, 2'b01));
    @(posedge clk); #1;
    rst_n           = 1'b0;
    bus.i_req_valid = 2'b00;
    @(posedge clk); #1;
    rsp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst ram_addr", 64'(bus.o_ram_addr), 64'(0));
    chk("post_rst ram_we", 64'(bus.o_ram_we), 64'(0));

    // Pointer was 1 before reset; after reset requester 0 must win.
    apply(mk("post_rst_ptr", 2'b11, 2'b00, 8'h14, 8'h15, 32'h0, 32'h0, 2'b01));
`ifdef SPRAM_ARB_BURST_EN
    apply(mk("burst_keep", 2'b11, 2'b00, 8'h16, 8'h15, 32'h0, 32'h0, 2'b01));
    apply(mk("burst_drop", 2'b10, 2'b00, 8'h00, 8'h15, 32'h0, 32'h0, 2'b10));
`else
    apply(mk("rr_alt", 2'b11, 2'b00, 8'h16, 8'h15, 32'h0, 32'h0, 2'b10));
`endif
    for (int k = 0; k < 4; k++) apply(mk("drain", 2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 2'b00));

    chk("scoreboard empty", 64'(cmd_q.size() + rsp_q.size()), 64'(0));
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
